// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the multi-cycle LEGv8
// controller. It holds the state and instruction-class enums, the 11-bit
// opcode casez patterns (instr[31:21]), the ALU operation codes, and the
// ALU source and transfer-size encodings.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  // Byte and doubleword transfers share one class and are told apart by
  // the is_byte flag from the decoder.
  typedef enum logic [3:0] {
    CLS_B,
    CLS_BLT,
    CLS_CBZ,
    CLS_ADDI,
    CLS_ADDS,
    CLS_SUBS,
    CLS_MOVZ,
    CLS_MOVK,
    CLS_LDUR,
    CLS_STUR,
    CLS_ILLEGAL
  } instr_class_e;

  // Opcode patterns on instr[31:21]. In a casez match, '?' bits are don't-care.
  localparam logic [10:0] OP_B     = 11'b000101?????;
  localparam logic [10:0] OP_BCOND = 11'b01010100???;
  localparam logic [10:0] OP_CBZ   = 11'b10110100???;
  localparam logic [10:0] OP_ADDI  = 11'b1001000100?;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_MOVZ  = 11'b110100101??;
  localparam logic [10:0] OP_MOVK  = 11'b111100101??;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;
  localparam logic [10:0] OP_STURB = 11'b00111000000;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;

  localparam logic [1:0] ALU_SRC_REG    = 2'b00;
  localparam logic [1:0] ALU_SRC_DADDR9 = 2'b01;
  localparam logic [1:0] ALU_SRC_IMM12  = 2'b10;

  localparam logic [3:0] XFER_SIZE_DWORD = 4'b1000;
  localparam logic [3:0] XFER_SIZE_BYTE  = 4'b0001;

endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational opcode classifier.
//   opcode  in  11  instr[31:21]
//   cls     out     instruction class (CLS_ILLEGAL when nothing matches)
//   is_byte out  1  1 for LDURB/STURB
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0]  opcode,
  output instr_class_e cls,
  output logic         is_byte
);

  always_comb begin
    cls     = CLS_ILLEGAL;
    is_byte = 1'b0;
    casez (opcode)
      OP_B:     cls = CLS_B;
      OP_BCOND: cls = CLS_BLT;
      OP_CBZ:   cls = CLS_CBZ;
      OP_ADDI:  cls = CLS_ADDI;
      OP_ADDS:  cls = CLS_ADDS;
      OP_SUBS:  cls = CLS_SUBS;
      OP_MOVZ:  cls = CLS_MOVZ;
      OP_MOVK:  cls = CLS_MOVK;
      OP_LDUR:  cls = CLS_LDUR;
      OP_STUR:  cls = CLS_STUR;
      OP_LDURB: begin
        cls     = CLS_LDUR;
        is_byte = 1'b1;
      end
      OP_STURB: begin
        cls     = CLS_STUR;
        is_byte = 1'b1;
      end
      default:  cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing controller for the multi-cycle LEGv8
// datapath. It steps each instruction through FETCH, DECODE, EXECUTE,
// MEMORY and WRITEBACK, and drives the datapath enables and selects.
//   clk, reset (async, active-high)
//   instr[31:21] decoded; zero/negative/overflow feed the branch decisions
//   mem_ready    data-memory acknowledge, honoured only in MEMORY
//   outputs      ir_write, pc_write, br_taken, uncond_br, reg2loc, alu_src,
//                alu_cntrl, flag_write, reg_write, mem_to_reg, movz, movk,
//                mem_write, read_enable, xfer_size, illegal (sticky), state
// Optional: `define MULTICYCLE_PERF_EN adds the 32-bit cycle_count and
// instr_count outputs.
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        negative,
  input  logic        overflow,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        br_taken,
  output logic        uncond_br,
  output logic        reg2loc,
  output logic [1:0]  alu_src,
  output logic [2:0]  alu_cntrl,
  output logic        flag_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        movz,
  output logic        movk,
  output logic        mem_write,
  output logic        read_enable,
  output logic [3:0]  xfer_size,
  output logic        illegal,
  output logic [2:0]  state
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  state_e       state_q, state_d;
  logic         illegal_q, illegal_d;
  instr_class_e cls;
  logic         is_byte;

  // Only the opcode field is decoded here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[20:0];

  instr_class_decode u_decode (
    .opcode  (instr[31:21]),
    .cls     (cls),
    .is_byte (is_byte)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        case (cls)
          CLS_B, CLS_BLT, CLS_CBZ:                     state_d = ST_FETCH;
          CLS_ADDI, CLS_ADDS, CLS_SUBS,
          CLS_MOVZ, CLS_MOVK:                          state_d = ST_WRITEBACK;
          CLS_LDUR, CLS_STUR:                          state_d = ST_MEMORY;
          default: begin
            state_d   = ST_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEMORY: begin
        if (mem_ready) begin
          state_d = (cls == CLS_LDUR) ? ST_WRITEBACK : ST_FETCH;
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Control outputs are decoded from the current state rather than
  // registered: branch outcomes follow the live zero/flag inputs in EXECUTE,
  // and every strobe must drop the moment reset asserts.
  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    br_taken    = 1'b0;
    uncond_br   = 1'b0;
    reg2loc     = 1'b0;
    alu_src     = ALU_SRC_REG;
    alu_cntrl   = ALU_PASS_B;
    flag_write  = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    movz        = 1'b0;
    movk        = 1'b0;
    mem_write   = 1'b0;
    read_enable = 1'b0;
    xfer_size   = '0;
    if (!reset) begin
      case (state_q)
        ST_FETCH:  ir_write = 1'b1;
        ST_DECODE: reg2loc  = (cls == CLS_ADDS) || (cls == CLS_SUBS);
        ST_EXECUTE: begin
          case (cls)
            CLS_B: begin
              pc_write  = 1'b1;
              br_taken  = 1'b1;
              uncond_br = 1'b1;
            end
            CLS_BLT: begin
              pc_write = 1'b1;
              br_taken = negative ^ overflow;
            end
            CLS_CBZ: begin
              alu_cntrl = ALU_PASS_B;
              pc_write  = 1'b1;
              br_taken  = zero;
            end
            CLS_ADDI: begin
              alu_src   = ALU_SRC_IMM12;
              alu_cntrl = ALU_ADD;
            end
            CLS_ADDS: begin
              alu_cntrl  = ALU_ADD;
              flag_write = 1'b1;
            end
            CLS_SUBS: begin
              alu_cntrl  = ALU_SUB;
              flag_write = 1'b1;
            end
            CLS_MOVZ, CLS_MOVK: ;
            CLS_LDUR, CLS_STUR: begin
              alu_src   = ALU_SRC_DADDR9;
              alu_cntrl = ALU_ADD;
            end
            default: pc_write = 1'b1;
          endcase
        end
        ST_MEMORY: begin
          xfer_size   = is_byte ? XFER_SIZE_BYTE : XFER_SIZE_DWORD;
          read_enable = (cls == CLS_LDUR);
          mem_write   = (cls == CLS_STUR);
          pc_write    = (cls == CLS_STUR) && mem_ready;
        end
        ST_WRITEBACK: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          mem_to_reg = (cls == CLS_LDUR);
          movz       = (cls == CLS_MOVZ);
          movk       = (cls == CLS_MOVK);
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instr_count_q, instr_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q + 32'd1;
    instr_count_d = instr_count_q + {31'd0, pc_write};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control. The driver
// issues instructions and pushes one expected output snapshot per cycle;
// the monitor pops and compares on each falling clock edge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero, negative, overflow, mem_ready;
  logic        ir_write, pc_write, br_taken, uncond_br, reg2loc;
  logic [1:0]  alu_src;
  logic [2:0]  alu_cntrl;
  logic        flag_write, reg_write, mem_to_reg, movz, movk;
  logic        mem_write, read_enable;
  logic [3:0]  xfer_size;
  logic        illegal;
  logic [2:0]  state;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .zero        (zero),
    .negative    (negative),
    .overflow    (overflow),
    .mem_ready   (mem_ready),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .br_taken    (br_taken),
    .uncond_br   (uncond_br),
    .reg2loc     (reg2loc),
    .alu_src     (alu_src),
    .alu_cntrl   (alu_cntrl),
    .flag_write  (flag_write),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .movz        (movz),
    .movk        (movk),
    .mem_write   (mem_write),
    .read_enable (read_enable),
    .xfer_size   (xfer_size),
    .illegal     (illegal),
    .state       (state)
`ifdef MULTICYCLE_PERF_EN
    ,
    .cycle_count (cycle_count),
    .instr_count (instr_count)
`endif
  );

  typedef struct packed {
    logic       ir_write, pc_write, br_taken, uncond_br, reg2loc;
    logic [1:0] alu_src;
    logic [2:0] alu_cntrl;
    logic       flag_write, reg_write, mem_to_reg, movz, movk;
    logic       mem_write, read_enable;
    logic [3:0] xfer_size;
    logic       illegal;
    logic [2:0] state;
  } obs_t;

  typedef struct {
    obs_t exp;
    int   ino;
    int   cyc;
  } item_t;

  obs_t obs_act;
  assign obs_act = {ir_write, pc_write, br_taken, uncond_br, reg2loc, alu_src,
                    alu_cntrl, flag_write, reg_write, mem_to_reg, movz, movk,
                    mem_write, read_enable, xfer_size, illegal, state};

  localparam int K_B = 0, K_BLT = 1, K_CBZ = 2, K_ADDI = 3, K_ADDS = 4,
                 K_SUBS = 5, K_MOVZ = 6, K_MOVK = 7, K_LD = 8, K_ST = 9,
                 K_ILL = 10;

  // Instruction set as (mask, value) pairs on instr[31:21].
  localparam int NT = 12;
  localparam logic [10:0] T_MASK [NT] = '{
    11'b11111100000, 11'b11111111000, 11'b11111111000, 11'b11111111110,
    11'b11111111111, 11'b11111111111, 11'b11111111100, 11'b11111111100,
    11'b11111111111, 11'b11111111111, 11'b11111111111, 11'b11111111111};
  localparam logic [10:0] T_VAL [NT] = '{
    11'b00010100000, 11'b01010100000, 11'b10110100000, 11'b10010001000,
    11'b10101011000, 11'b11101011000, 11'b11010010100, 11'b11110010100,
    11'b11111000010, 11'b11111000000, 11'b00111000010, 11'b00111000000};
  localparam int T_CLS [NT] = '{K_B, K_BLT, K_CBZ, K_ADDI, K_ADDS, K_SUBS,
                                K_MOVZ, K_MOVK, K_LD, K_ST, K_LD, K_ST};
  localparam bit T_BYTE [NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    ino = 0;
  bit    ill_model = 1'b0;
  int    cyc_model = 0;
  int    instr_model = 0;

  task automatic classify(input logic [10:0] op, output int cls, output bit byt);
    cls = K_ILL;
    byt = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (cls == K_ILL && (op & T_MASK[i]) == T_VAL[i]) begin
        cls = T_CLS[i];
        byt = T_BYTE[i];
      end
    end
  endtask

  // Expected outputs for one cycle, from the phase of the instruction.
  // pc_write follows the rule "exactly once, in the final cycle".
  function automatic obs_t expect_cycle(input int cls, input bit byt, input int ph,
                                        input bit last, input bit z, input bit n,
                                        input bit v, input bit ill);
    obs_t e = '0;
    e.state    = 3'(ph);
    e.illegal  = ill;
    e.pc_write = last;
    case (ph)
      0: e.ir_write = 1'b1;
      1: e.reg2loc = (cls == K_ADDS) || (cls == K_SUBS);
      2: begin
        case (cls)
          K_B:    begin e.br_taken = 1'b1; e.uncond_br = 1'b1; end
          K_BLT:  e.br_taken = n ^ v;
          K_CBZ:  e.br_taken = z;
          K_ADDI: begin e.alu_src = 2'b10; e.alu_cntrl = 3'b010; end
          K_ADDS: begin e.alu_cntrl = 3'b010; e.flag_write = 1'b1; end
          K_SUBS: begin e.alu_cntrl = 3'b011; e.flag_write = 1'b1; end
          K_LD, K_ST: begin e.alu_src = 2'b01; e.alu_cntrl = 3'b010; end
          default: ;
        endcase
      end
      3: begin
        e.read_enable = (cls == K_LD);
        e.mem_write   = (cls == K_ST);
        e.xfer_size   = byt ? 4'b0001 : 4'b1000;
      end
      4: begin
        e.reg_write  = 1'b1;
        e.mem_to_reg = (cls == K_LD);
        e.movz       = (cls == K_MOVZ);
        e.movk       = (cls == K_MOVK);
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_now(input string name, input obs_t exp);
    n_cmp++;
    if (obs_act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, obs_act, exp);
    end
  endtask

`ifdef MULTICYCLE_PERF_EN
  task automatic check_u32(input string name, input logic [31:0] act, input int req);
    n_cmp++;
    if (act !== 32'(req)) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
`endif

  task automatic rand_flags();
    zero     = 1'($urandom_range(0, 1));
    negative = 1'($urandom_range(0, 1));
    overflow = 1'($urandom_range(0, 1));
  endtask

  // Entered and left at posedge+1, with the DUT in FETCH.
  task automatic run_instr(input logic [10:0] op, input int w, input bit force_flags,
                           input bit fz, input bit fn, input bit fv);
    int          cls, lat, ph;
    bit          byt, ill_next;
    logic [31:0] r;
    item_t       it;
    classify(op, cls, byt);
    if (cls == K_B || cls == K_BLT || cls == K_CBZ || cls == K_ILL) lat = 3;
    else if (cls == K_ST) lat = 4 + w;
    else if (cls == K_LD) lat = 5 + w;
    else lat = 4;
    r = $urandom();
    instr = {op, r[20:0]};
    ill_next = ill_model;
    for (int c = 0; c < lat; c++) begin
      if (c < 3) ph = c;
      else if ((cls == K_LD || cls == K_ST) && c <= 3 + w) ph = 3;
      else ph = 4;
      rand_flags();
      if (ph == 2 && force_flags) begin
        zero = fz; negative = fn; overflow = fv;
      end
      mem_ready = (ph == 3) ? (c == 3 + w) : 1'($urandom_range(0, 1));
      it.exp = expect_cycle(cls, byt, ph, c == lat - 1, zero, negative, overflow, ill_model);
      it.ino = ino;
      it.cyc = c;
      exp_q.push_back(it);
      if (ph == 2 && cls == K_ILL) ill_next = 1'b1;
      @(posedge clk); #1;
      ill_model = ill_next;
      cyc_model++;
      if (c == lat - 1) instr_model++;
    end
    ino++;
`ifdef MULTICYCLE_PERF_EN
    check_u32("instr_count", instr_count, instr_model);
    check_u32("cycle_count", cycle_count, cyc_model);
`endif
  endtask

  // STUR stalled in MEMORY, then reset asserted in the middle of a cycle.
  task automatic reset_mid_store();
    logic [31:0] r;
    item_t       it;
    int          ph;
    r = $urandom();
    instr = {11'b11111000000, r[20:0]};
    for (int c = 0; c < 5; c++) begin
      ph = (c < 3) ? c : 3;
      rand_flags();
      mem_ready = (ph == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      it.exp = expect_cycle(K_ST, 1'b0, ph, 1'b0, zero, negative, overflow, ill_model);
      it.ino = ino;
      it.cyc = c;
      exp_q.push_back(it);
      if (c < 4) begin
        @(posedge clk); #1;
        cyc_model++;
      end
    end
    ino++;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check_now("reset_async_drop", '0);
    @(posedge clk); #1;
    check_now("reset_hold", '0);
    reset = 1'b0;
    ill_model   = 1'b0;
    cyc_model   = 0;
    instr_model = 0;
  endtask

  // Monitor: compare the DUT against the next queued expectation.
  item_t mon_it;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_it = exp_q.pop_front();
      n_cmp++;
      if (obs_act !== mon_it.exp) begin
        n_err++;
        $display("FAIL trace i%0d c%0d actual=%h required=%h",
                 mon_it.ino, mon_it.cyc, obs_act, mon_it.exp);
      end
      n_cmp++;
      if (reg_write === 1'b1 && mem_write === 1'b1) begin
        n_err++;
        $display("FAIL write_exclusive i%0d c%0d actual=11 required=not both",
                 mon_it.ino, mon_it.cyc);
      end
    end
  end

  initial begin
    logic [10:0] op, r11;
    int          k;
    reset = 1'b1;
    instr = '0;
    zero = 1'b0; negative = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", '0);
    reset = 1'b0;

    run_instr(11'b10010001000, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // ADDI
    run_instr(11'b00111000010, 3, 1'b0, 1'b0, 1'b0, 1'b0);  // LDURB, W=3
    run_instr(11'b01010100000, 0, 1'b1, 1'b0, 1'b1, 1'b0);  // B.LT taken
    run_instr(11'b01010100000, 0, 1'b1, 1'b0, 1'b1, 1'b1);  // B.LT not taken
    run_instr(11'b11101011000, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // SUBS
    run_instr(11'b10110100000, 0, 1'b1, 1'b1, 1'b0, 1'b0);  // CBZ zero=1
    run_instr(11'b00000000000, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // illegal
    run_instr(11'b10101011000, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // ADDS after illegal
    run_instr(11'b11111000000, 2, 1'b0, 1'b0, 1'b0, 1'b0);  // STUR, W=2

    for (int i = 0; i < 150; i++) begin
      r11 = 11'($urandom());
      if ($urandom_range(0, 7) == 0) begin
        op = r11;
      end else begin
        k  = $urandom_range(0, NT - 1);
        op = T_VAL[k] | (r11 & ~T_MASK[k]);
      end
      run_instr(op, $urandom_range(0, 4), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    reset_mid_store();
    run_instr(11'b10010001001, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // ADDI after reset
    run_instr(11'b11111000010, 1, 1'b0, 1'b0, 1'b0, 1'b0);  // LDUR, W=1

    @(posedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle LEGv8 datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and drives the datapath enables and selects in each state. It holds in MEMORY until data memory acknowledges. It sits beside the instruction register and replaces the single-cycle decoder as the sole source of datapath control.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high; forces FETCH and all outputs to reset values
- instr  input  32  instruction register contents; only [31:21] are decoded
- zero  input  1  live ALU zero flag, used in EXECUTE by CBZ
- negative, overflow  input  1 each  stored flag-register bits, used by B.LT
- mem_ready  input  1  data-memory acknowledge, sampled only in MEMORY
- ir_write  output  1  load instruction register
- pc_write  output  1  update PC this cycle
- br_taken, uncond_br  output  1 each  PC source select: branch target when br_taken; uncond_br selects the B-format offset
- reg2loc  output  1  1 = Rm, 0 = Rd on register read port 2
- alu_src  output  2  00 reg, 01 DAddr9, 10 Imm12
- alu_cntrl  output  3  000 pass B, 010 add, 011 sub
- flag_write  output  1  load flag register
- reg_write, mem_to_reg, movz, movk  output  1 each  writeback controls
- mem_write, read_enable  output  1 each  data-memory strobes
- xfer_size  output  4  1000 for 64-bit, 0001 for byte
- illegal  output  1  sticky flag, set by an undecodable opcode
- state  output  3  current state, for debug

## Operation
- States: FETCH(0), DECODE(1), EXECUTE(2), MEMORY(3), WRITEBACK(4). Undefined encodings go to FETCH.
- FETCH: ir_write=1 for one cycle. Next state is DECODE.
- DECODE: reg2loc is driven per class. No writes occur. Next state is EXECUTE.
- EXECUTE behaviour by class:
  - B: pc_write=1, br_taken=1, uncond_br=1. Next state is FETCH.
  - B.LT: pc_write=1, br_taken=negative^overflow. Next state is FETCH.
  - CBZ: alu_cntrl=000, pc_write=1, br_taken=zero. Next state is FETCH.
  - ADDI, ADDS, SUBS: ALU op is driven. ADDS and SUBS also assert flag_write. Next state is WRITEBACK.
  - MOVZ, MOVK: next state is WRITEBACK.
  - LDUR(B), STUR(B): alu_src=01, add. Next state is MEMORY.
  - Illegal opcode: pc_write=1 (sequential PC), illegal is set. Next state is FETCH.
- MEMORY:
  - Load: read_enable=1. Store: mem_write=1.
  - xfer_size is driven and held until mem_ready=1.
  - On mem_ready, a store asserts pc_write and goes to FETCH; a load goes to WRITEBACK.
- WRITEBACK:
  - reg_write=1 and pc_write=1.
  - mem_to_reg=1 for loads; movz/movk asserted for MOVZ/MOVK.
  - Next state is FETCH.
- Every output not listed for a state is driven 0. No output is ever z or x.
- illegal clears only on reset.

## Timing
- Reset value: state=FETCH, every output 0, illegal=0.
- Instruction latency in cycles:
  - B, B.LT, CBZ, illegal: 3.
  - ALU ops and MOV: 4.
  - STUR(B): 4+W. LDUR(B): 5+W. W = extra MEMORY cycles before mem_ready.
- mem_ready high in the first MEMORY cycle gives W=0. mem_ready outside MEMORY is ignored.
- pc_write pulses exactly once per instruction, in its final cycle.
- reg_write and mem_write never both assert in the same cycle.
- Reset mid-instruction abandons the instruction with no pending write. A write strobe asserted in the reset cycle drops asynchronously.
- instr must stay stable from DECODE through the end of the instruction.

## Configuration
- MULTICYCLE_PERF_EN:
  - Defined: adds 32-bit outputs cycle_count and instr_count, both reset to 0.
  - cycle_count increments every cycle.
  - instr_count increments on each pc_write.
  - Both wrap from 0xFFFFFFFF to 0.
  - Undefined: the ports and counters are absent.

## Structure
- Package cpu_ctrl_pkg holds:
  - the state enum;
  - the instruction-class enum;
  - opcode casez patterns;
  - ALU codes (PASS_B, ADD, SUB);
  - ALU_SRC and XFER_SIZE constants.
- Sub-module instr_class_decode (combinational): instr[31:21] -> class enum plus is_byte.
- The FSM and output decode stay in multicycle_control.

## Test plan
- Reset asserted mid-MEMORY of STUR -> mem_write drops immediately; state=0 after reset releases.
- ADDI X1,X31,#5 -> states 0,1,2,4. alu_src=10, alu_cntrl=010 in EXECUTE. reg_write=1 and pc_write=1 only in WRITEBACK.
- LDURB with mem_ready delayed 3 cycles:
  - read_enable=1 and xfer_size=0001 held for 4 MEMORY cycles;
  - then WRITEBACK with mem_to_reg=1;
  - 8 cycles total.
- B.LT with negative=1, overflow=0 -> br_taken=1 in cycle 3. With negative=1, overflow=1 -> br_taken=0. pc_write=1 in both cases.
- SUBS then CBZ with zero=1 -> flag_write=1 in SUBS EXECUTE only. CBZ gives br_taken=1, reg2loc=0.
- Opcode 0x000 -> illegal=1 after 3 cycles; the next valid instruction still executes; illegal stays 1. With MULTICYCLE_PERF_EN, instr_count=2.
